// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo
// Receive-side byte queue placed after the deserializer. Every rising edge of
// rx_received enqueues rx_data. The consumer drains the queue through a
// first-word-fall-through valid/ready port. A byte that arrives while the
// queue is full is dropped, and the sticky overflow flag is raised.
//
// Ports
//   clk          in   rising-edge system clock
//   rst          in   asynchronous, active-low reset
//   rx_data      in   [7:0] byte from the deserializer
//   rx_received  in   level from the deserializer; each rising edge is one byte
//   rd_data      out  [7:0] head byte, meaningful while rd_valid=1
//   rd_valid     out  queue not empty
//   rd_ready     in   consumer takes the head byte this cycle
//   count        out  [DEPTH_LOG2:0] number of stored bytes
//   full         out  count == 2^DEPTH_LOG2
//   empty        out  count == 0
//   overflow     out  sticky "byte dropped" flag
//   clr_overflow in   synchronous clear of overflow (a new drop wins)
module rx_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_received,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  recv_q;

  logic                  wr_req;
  logic                  rd_fire;
  logic                  wr_accept;
  logic                  wr_drop;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  full_next;
  logic                  empty_next;
  logic                  overflow_next;

  // Handshake decode, count arithmetic and overflow next-state.
  always_comb begin
    wr_req        = rx_received & ~recv_q;
    rd_fire       = ~empty & rd_ready;
    // A read in the same cycle frees a slot, so a full queue still accepts.
    wr_accept     = wr_req & (~full | rd_fire);
    wr_drop       = wr_req & full & ~rd_fire;
    count_next    = count;
    overflow_next = overflow;

    case ({wr_accept, rd_fire})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase

    // Set has priority over clear.
    if (wr_drop) begin
      overflow_next = 1'b1;
    end else if (clr_overflow) begin
      overflow_next = 1'b0;
    end else begin
      overflow_next = overflow;
    end

    full_next  = (count_next == DEPTH_CNT);
    empty_next = (count_next == CNT_ZERO);
  end

  // Pointers, count, status flags and edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= {DEPTH_LOG2{1'b0}};
      rd_ptr   <= {DEPTH_LOG2{1'b0}};
      count    <= CNT_ZERO;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      // Held high so a level already asserted at reset release is not a new byte.
      recv_q   <= 1'b1;
    end else begin
      recv_q   <= rx_received;
      count    <= count_next;
      full     <= full_next;
      empty    <= empty_next;
      overflow <= overflow_next;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Byte storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Head of queue, visible without a read cycle.
  always_comb begin
    rd_data  = mem[rd_ptr];
    rd_valid = ~empty;
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
module tb_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_received = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int         n_checks = 0;
  int         n_fail = 0;
  int         max_cnt = 0;
  logic [7:0] exp_q [$];

  rx_byte_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_received(rx_received),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every accepted read is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%0h, expected no byte", rd_data);
      end else begin
        check("rd_data_order", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle high pulse followed by one low cycle so the next pulse is a fresh edge.
  task automatic pulse(input logic [7:0] d, input bit expect_store);
    if (expect_store) exp_q.push_back(d);
    rx_data = d;
    rx_received = 1'b1;
    tick();
    rx_received = 1'b0;
    tick();
  endtask

  task automatic read_n(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("reset_rd_valid", rd_valid, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_count", count, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b1;
    tick();

    // Single byte
    exp_q.push_back(8'h5A);
    rx_data = 8'h5A;
    rx_received = 1'b1;
    tick();
    rx_received = 1'b0;
    check("single_rd_valid", rd_valid, 1);
    check("single_rd_data", rd_data, 8'h5A);
    check("single_count", count, 1);
    read_n(1);
    check("single_drained_valid", rd_valid, 0);
    check("single_drained_empty", empty, 1);

    // Held level stores exactly one byte
    exp_q.push_back(8'h11);
    rx_data = 8'h11;
    rx_received = 1'b1;
    repeat (20) tick();
    rx_received = 1'b0;
    check("held_count", count, 1);
    read_n(1);
    check("held_drained_empty", empty, 1);

    // Fill, overflow, order
    for (int i = 0; i < 16; i++) pulse(8'(i), 1'b1);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    pulse(8'hFF, 1'b0);
    check("drop_overflow", overflow, 1);
    check("drop_count", count, 16);
    read_n(16);
    check("fill_drained_empty", empty, 1);
    check("overflow_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("overflow_cleared", overflow, 0);

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) pulse(8'h20 + 8'(i), 1'b1);
    check("full2_full", full, 1);
    exp_q.push_back(8'hA5);
    rx_data = 8'hA5;
    rx_received = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_received = 1'b0;
    rd_ready = 1'b0;
    check("rw_full_overflow", overflow, 0);
    check("rw_full_count", count, 16);
    check("rw_full_full", full, 1);
    tick();
    read_n(16);
    check("rw_full_drained", empty, 1);
    check("rw_full_scoreboard", exp_q.size(), 0);

    // Wrap-around with interleaved traffic
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      rd_ready = (i % 2 == 1);
      pulse(8'(i * 7 + 3), 1'b1);
    end
    begin
      int guard;
      guard = 0;
      rd_ready = 1'b1;
      while (rd_valid && guard < 64) begin
        tick();
        guard++;
      end
      rd_ready = 1'b0;
      check("wrap_drain_timeout", rd_valid, 0);
    end
    check("wrap_scoreboard", exp_q.size(), 0);
    check("wrap_max_count_le_16", int'(max_cnt <= 16), 1);
    check("wrap_empty", empty, 1);

    // Reset mid-operation with rx_received held high
    for (int i = 0; i < 16; i++) pulse(8'h60 + 8'(i), 1'b1);
    pulse(8'hFF, 1'b0);
    read_n(12);
    exp_q.push_back(8'h77);
    rx_data = 8'h77;
    rx_received = 1'b1;
    tick();
    check("pre_reset_count", count, 5);
    check("pre_reset_overflow", overflow, 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_count", count, 0);
    check("midreset_empty", empty, 1);
    check("midreset_overflow", overflow, 0);
    check("midreset_rd_valid", rd_valid, 0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("post_reset_no_write", count, 0);
    check("post_reset_empty", empty, 1);
    rx_received = 1'b0;
    tick();
    pulse(8'h99, 1'b1);
    check("post_reset_new_count", count, 1);
    check("post_reset_new_data", rd_data, 8'h99);
    read_n(1);
    check("final_empty", empty, 1);
    check("final_scoreboard", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Receive-side byte buffer that sits directly downstream of the `deserializer`. It captures every byte the deserializer flags on `received` and queues it in a small FIFO. Bytes are presented to the consumer (display/echo logic) through a valid/ready handshake, and any byte lost because the queue was full is flagged. This decouples the UART receive rate from the consumer's read rate.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4. Address width; FIFO depth = 2^DEPTH_LOG2 (16 bytes by default).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `rx_data`  in  8  byte from `deserializer.data`.
- `rx_received`  in  1  from `deserializer.received`. A rising edge marks a new byte; the level may stay high for any number of cycles.
- `rd_data`  out  8  byte at the FIFO head; valid only while `rd_valid`=1.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer accepts the head byte this cycle.
- `count`  out  DEPTH_LOG2+1  number of stored bytes, 0..2^DEPTH_LOG2.
- `full`  out  1  count == 2^DEPTH_LOG2.
- `empty`  out  1  count == 0.
- `overflow`  out  1  sticky flag; a byte was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation

- Edge detect:
  - `recv_q` registers `rx_received` every cycle.
  - `wr_req` = `rx_received` & ~`recv_q`.
  - Exactly one write request per rising edge of `rx_received`, regardless of how long the level is held.
- Storage:
  - Dual-pointer RAM of 2^DEPTH_LOG2 x 8.
  - `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is held in its own register.
- Write, on `wr_req`:
  - If not full: `rx_data` is stored at `wr_ptr` and `wr_ptr`++.
  - If full and no read this cycle: the byte is dropped, pointers are unchanged, and `overflow` is set to 1.
- Read: `rd_fire` = `rd_valid` & `rd_ready`. `rd_ptr`++ on `rd_fire`.
- `rd_data` = mem[`rd_ptr`], a combinational read of the head (first-word fall-through).
- `rd_valid` = ~`empty`. `rd_ready` is ignored while empty; no underflow is possible.
- Simultaneous events:
  - Write and read in the same cycle: both are performed and `count` is unchanged.
  - This holds when full: the read frees a slot and the write is accepted, with no overflow.
  - Write to empty with `rd_ready`=1: the byte is stored and not read in that cycle.
  - `clr_overflow` and a new overflow in the same cycle: set wins and `overflow` stays 1.
- Count update: `count` += (write accepted) − `rd_fire`. It never exceeds 2^DEPTH_LOG2 and never goes below 0.
- Reset (rst=0, asynchronous):
  - `wr_ptr`=`rd_ptr`=0, `count`=0, `overflow`=0.
  - `recv_q`=1, so a `rx_received` held high across reset release does not create a spurious write.
  - Output values during reset: `rd_valid`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0.
  - `rd_data` is don't-care; RAM contents are not cleared.
  - Reset mid-operation discards all queued bytes immediately.

## Timing

- Write latency:
  - `rx_received` rises before clock edge N, so `wr_req` is high in that cycle.
  - At edge N: `rx_data` is captured, and `count`, `empty` and `rd_valid` update.
  - `rd_valid`=1 and `rd_data` = the byte are visible right after edge N. Latency is 1 clock.
  - `rx_data` must be stable in the cycle in which `wr_req` is high. `deserializer` guarantees this because `data` is valid when `received` rises.
- Read: with `rd_valid`=1 and `rd_ready`=1 before edge M, the next byte (or `rd_valid`=0) appears right after edge M.
- Sustained throughput: one write and one read per clock.
- Status: `full`, `empty` and `count` are all derived from the `count` register, so they update together on the same edge.
- `overflow` rises on the edge where the dropped write occurs.

## Test plan

- Single byte:
  - Reset, then pulse `rx_received` with `rx_data`=0x5A, `rd_ready`=0.
  - Required: `rd_valid`=1, `rd_data`=0x5A, `count`=1 one clock later.
  - Then `rd_ready`=1 for one cycle. Required: `rd_valid`=0, `empty`=1.
- Held level: hold `rx_received` high for 20 cycles with `rx_data`=0x11. Required: exactly one byte stored, `count`=1.
- Fill, overflow and order:
  - Write 0x00..0x0F (16 bytes). Required: `full`=1, `count`=16.
  - Write 0xFF. Required: it is dropped, `overflow`=1, `count`=16.
  - Read all 16 bytes. Required: order is 0x00..0x0F.
  - Assert `clr_overflow`. Required: `overflow`=0.
- Full plus simultaneous read/write:
  - With the FIFO full, pulse write 0xA5 in the same cycle as a read.
  - Required: `overflow` stays 0, `count`=16, and 0xA5 is read out last.
- Wrap-around: run 40 bytes through with an interleaved write/read pattern. Required: output sequence equals input sequence, and `count` never exceeds 16.
- Reset mid-operation:
  - With `count`=5 and `rx_received` held high, assert `rst`=0, then release it.
  - Required: `count`=0, `empty`=1, `overflow`=0, and no write occurs until the next rising edge of `rx_received`.
